// File: rtl/pipe_run_ctrl_pkg.sv
// Shared types and default widths for the pipeline run/step/halt controller.
// Contents: state_t (controller state), cause_t (reason for the last stop),
//           default widths for the PC, the step counter and the cycle counter.
package pipe_run_ctrl_pkg;

  localparam int PC_W_DEF     = 12;
  localparam int STEP_W_DEF   = 8;
  localparam int CNT_W_DEF    = 32;
  localparam int WDOG_LIM_DEF = 1 << 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_NONE     = 3'd0,
    C_USER     = 3'd1,
    C_STEPDONE = 3'd2,
    C_BREAK    = 3'd3,
    C_SYSCALL  = 3'd4,
    C_WDOG     = 3'd5
  } cause_t;

endpackage

// File: rtl/pipe_run_ctrl_if.sv
// Bundle between the debug/console side (master) and the run controller (slave).
// Master drives: run_req/step_req/stop_req pulses, step_count, pc, bp_en/bp_addr,
//   syscall_halt. Slave drives: go, state, stop_cause, cycle_cnt.
interface pipe_run_ctrl_if #(
  parameter int PC_W   = pipe_run_ctrl_pkg::PC_W_DEF,
  parameter int STEP_W = pipe_run_ctrl_pkg::STEP_W_DEF,
  parameter int CNT_W  = pipe_run_ctrl_pkg::CNT_W_DEF
) ();
  import pipe_run_ctrl_pkg::*;

  logic              run_req;
  logic              step_req;
  logic              stop_req;
  logic [STEP_W-1:0] step_count;
  logic [PC_W-1:0]   pc;
  logic              bp_en;
  logic [PC_W-1:0]   bp_addr;
  logic              syscall_halt;
  logic              go;
  state_t            state;
  cause_t            stop_cause;
  logic [CNT_W-1:0]  cycle_cnt;

  modport master (
    output run_req, step_req, stop_req, step_count, pc, bp_en, bp_addr, syscall_halt,
    input  go, state, stop_cause, cycle_cnt
  );

  modport slave (
    input  run_req, step_req, stop_req, step_count, pc, bp_en, bp_addr, syscall_halt,
    output go, state, stop_cause, cycle_cnt
  );

endinterface

// File: rtl/pipe_run_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Latency: count visible the edge after en_i; clr_n_i (sync, active-low) wins over en_i.
// Ports: clk, clr_n_i (clear), en_i (count enable), cnt_o (registered count). No backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run/step/halt sequencer producing the pipeline advance enable (go).
// Latency: go is combinational from state/pc/syscall_halt; state/stop_cause/cycle_cnt
//   update on the next clk edge. No backpressure: request pulses not accepted are dropped.
// Ports: clk, rst (sync active-low), bus (pipe_run_ctrl_if.slave).
// Optional: define PIPE_RUN_CTRL_WATCHDOG_EN to stop a free run after WDOG_LIM advancing
//   cycles with cause WDOG; without it there is no watchdog hardware or WDOG_LIM parameter.
module pipe_run_ctrl
  import pipe_run_ctrl_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int STEP_W   = STEP_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
`ifdef PIPE_RUN_CTRL_WATCHDOG_EN
  ,
  parameter int WDOG_LIM = WDOG_LIM_DEF
`endif
) (
  input logic            clk,
  input logic            rst,
  pipe_run_ctrl_if.slave bus
);

  state_t            state_q;
  cause_t            cause_q;
  logic [STEP_W-1:0] remaining_q;
  logic              bp_skip_q;

  logic bp_hit;
  logic go;
  logic wdog_exit;

  // bp_skip_q masks the breakpoint for the first advancing cycle after a resume,
  // so the instruction sitting on the breakpoint executes once.
  assign bp_hit = bus.bp_en && (bus.pc == bus.bp_addr) && !bp_skip_q;
  assign go     = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_hit && !bus.syscall_halt;

  assign bus.go         = go;
  assign bus.state      = state_q;
  assign bus.stop_cause = cause_q;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .clr_n_i (rst),
    .en_i    (go),
    .cnt_o   (bus.cycle_cnt)
  );

`ifdef PIPE_RUN_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIM + 1);
  logic [WD_W-1:0] wdog_cnt;

  // Held in clear outside RUN, so it only ever counts one uninterrupted free run.
  sat_counter #(.W(WD_W)) u_wdog_cnt (
    .clk     (clk),
    .clr_n_i (rst && (state_q == ST_RUN)),
    .en_i    (go),
    .cnt_o   (wdog_cnt)
  );

  // The count reflects advances already taken; this go cycle is number WDOG_LIM.
  assign wdog_exit = go && (wdog_cnt == WD_W'(WDOG_LIM - 1));
`else
  assign wdog_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cause_q     <= C_NONE;
      remaining_q <= '0;
      bp_skip_q   <= 1'b0;
    end else begin
      if (go) begin
        bp_skip_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (bus.syscall_halt) begin
            state_q <= ST_HALT;
            cause_q <= C_SYSCALL;
          end else if (bus.stop_req) begin
            // Nothing to stop; it still masks a coincident run/step request.
          end else if (bus.run_req) begin
            state_q <= ST_RUN;
            cause_q <= C_NONE;
          end else if (bus.step_req && (bus.step_count != '0)) begin
            state_q     <= ST_STEP;
            cause_q     <= C_NONE;
            remaining_q <= bus.step_count;
          end
        end
        ST_RUN: begin
          if (bus.syscall_halt) begin
            state_q <= ST_HALT;
            cause_q <= C_SYSCALL;
          end else if (bp_hit) begin
            state_q   <= ST_IDLE;
            cause_q   <= C_BREAK;
            bp_skip_q <= 1'b1;
          end else if (bus.stop_req) begin
            state_q <= ST_IDLE;
            cause_q <= C_USER;
          end else if (wdog_exit) begin
            state_q <= ST_IDLE;
            cause_q <= C_WDOG;
          end
        end
        ST_STEP: begin
          if (bus.syscall_halt) begin
            state_q     <= ST_HALT;
            cause_q     <= C_SYSCALL;
            remaining_q <= '0;
          end else if (bp_hit) begin
            state_q     <= ST_IDLE;
            cause_q     <= C_BREAK;
            bp_skip_q   <= 1'b1;
            remaining_q <= '0;
          end else if (bus.stop_req) begin
            state_q     <= ST_IDLE;
            cause_q     <= C_USER;
            remaining_q <= '0;
          end else if (go) begin
            if (remaining_q == STEP_W'(1)) begin
              state_q <= ST_IDLE;
              cause_q <= C_STEPDONE;
            end
            remaining_q <= remaining_q - STEP_W'(1);
          end
        end
        ST_HALT: begin
          // Terminal until reset.
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
